// File: rtl/vec_exec_pipe.sv
// Multi-lane AES byte-op execution stage followed by an elastic, bubble-collapsing
// register pipeline with flush, occupancy count and destination-tag hazard query.
module vec_exec_pipe #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [2:0]                  in_op_i,
    input  logic [LANES*LANE_W-1:0]     in_a_i,
    input  logic [LANES*LANE_W-1:0]     in_b_i,
    input  logic [LANES-1:0]            in_mask_i,
    input  logic [TAG_W-1:0]            in_tag_i,
    input  logic                        flush_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*LANE_W-1:0]     out_result_o,
    output logic [TAG_W-1:0]            out_tag_o,
    output logic                        out_err_o,
    output logic [$clog2(STAGES+1)-1:0] inflight_o,
    input  logic [TAG_W-1:0]            chk_tag_i,
    output logic                        chk_hit_o
);

    localparam int DW    = LANES * LANE_W;
    localparam int BYTES = LANE_W / 8;
    localparam int CNT_W = $clog2(STAGES + 1);

    localparam logic [2:0] OP_XOR   = 3'd0;
    localparam logic [2:0] OP_BADD  = 3'd1;
    localparam logic [2:0] OP_ROTB  = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_PASSA = 3'd4;
    localparam logic [2:0] OP_XTIME = 3'd5;

    logic [DW-1:0]     res_c;
    logic              err_c;
    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic [LANE_W-1:0] lane_r;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] err_q;
    logic [DW-1:0]     data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  inflight_d;
    logic [STAGES-1:0] load;
    logic              accept;

    always_comb begin
        res_c  = '0;
        lane_a = '0;
        lane_b = '0;
        lane_r = '0;
        err_c  = (in_op_i > OP_XTIME);
        for (int l = 0; l < LANES; l++) begin
            lane_a = in_a_i[l*LANE_W +: LANE_W];
            lane_b = in_b_i[l*LANE_W +: LANE_W];
            lane_r = '0;
            case (in_op_i)
                OP_XOR:   lane_r = lane_a ^ lane_b;
                OP_BADD: begin
                    for (int j = 0; j < BYTES; j++) begin
                        lane_r[j*8 +: 8] = lane_a[j*8 +: 8] + lane_b[j*8 +: 8];
                    end
                end
                OP_ROTB:  lane_r = (lane_a << 8) | (lane_a >> (LANE_W - 8));
                OP_AND:   lane_r = lane_a & lane_b;
                OP_PASSA: lane_r = lane_a;
                OP_XTIME: begin
                    for (int j = 0; j < BYTES; j++) begin
                        lane_r[j*8 +: 8] = {lane_a[j*8 +: 7], 1'b0}
                                         ^ (lane_a[j*8+7] ? 8'h1B : 8'h00);
                    end
                end
                default:  lane_r = '0;
            endcase
            if (!in_mask_i[l]) begin
                lane_r = lane_a;
            end
            res_c[l*LANE_W +: LANE_W] = lane_r;
        end
    end

    // A stage may load when it is empty or when some stage ahead of it is
    // empty or the consumer is taking the head (bubbles collapse).
    always_comb begin
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic adv;
            adv = out_ready_i;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    adv = 1'b1;
                end
            end
            load[k] = !valid_q[k] || adv;
        end
    end

    assign in_ready_o = load[0] && !flush_i && !rst_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (load[0]) begin
                valid_d[0] = accept;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            inflight_d = inflight_d + CNT_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            err_q      <= '0;
            inflight_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            if (accept) begin
                data_q[0] <= res_c;
                tag_q[0]  <= in_tag_i;
                err_q[0]  <= err_c;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k] && valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                    err_q[k]  <= err_q[k-1];
                end
            end
        end
    end

    always_comb begin
        chk_hit_o = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (valid_q[k] && (tag_q[k] == chk_tag_i)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

    assign out_valid_o  = valid_q[STAGES-1];
    assign out_result_o = data_q[STAGES-1];
    assign out_tag_o    = tag_q[STAGES-1];
    assign out_err_o    = err_q[STAGES-1];
    assign inflight_o   = inflight_q;

endmodule
